// File: rtl/serial_stack_pkg.sv
// Shared types for the serial_stack word sequencer: FSM state encoding,
// default word width and the in_len width helper.
package serial_stack_pkg;

    localparam int NUM_BITS_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        POP  = 2'd2,
        CLR  = 2'd3
    } ssq_state_e;

    // Width needed to hold a bit count of 0..n inclusive.
    function automatic int len_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/serial_stack_seq.sv
// serial_stack_seq: loads a word of 1..NUM_BITS bits into an external
// serial_stack LSB-first, then pops it back out as an MSB-first bit stream
// with valid/ready backpressure.
//
// Handshake: a word is accepted on a cycle with in_valid & in_ready; a bit is
// transferred on a cycle with bit_valid & bit_ready. bit_data/bit_last hold
// steady while bit_valid is high and bit_ready is low. abort (outside IDLE)
// and reset suppress any push, pop or bit transfer in the cycle they are seen.
//
// Optional build macro: SERIAL_STACK_SEQ_STATS_EN adds the words_done and
// aborts counter outputs.
module serial_stack_seq
    import serial_stack_pkg::*;
#(
    parameter int NUM_BITS = NUM_BITS_DEFAULT,
    parameter int LEN_W    = len_w(NUM_BITS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NUM_BITS-1:0] in_data,
    input  logic [LEN_W-1:0]    in_len,
    input  logic                abort,
    output logic                bit_valid,
    input  logic                bit_ready,
    output logic                bit_data,
    output logic                bit_last,
    output logic                busy,
    output logic [1:0]          state_dbg,
    output logic                stk_push,
    output logic                stk_pop,
    output logic                stk_clear,
    output logic                stk_in,
    input  logic                stk_out
`ifdef SERIAL_STACK_SEQ_STATS_EN
    ,
    output logic [15:0]         words_done,
    output logic [7:0]          aborts
`endif
);

    ssq_state_e            state_q;
    logic [NUM_BITS-1:0]   shreg_q;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      cnt_q;

    logic [LEN_W-1:0]      len_sat;
    logic [LEN_W-1:0]      last_cnt;
    logic                  live;
    logic                  abort_hit;

    // Clamp the requested length to the stack depth.
    always_comb begin
        len_sat = in_len;
        if (in_len > LEN_W'(NUM_BITS)) begin
            len_sat = LEN_W'(NUM_BITS);
        end
    end

    assign last_cnt  = len_q - LEN_W'(1);
    assign live      = !reset && !abort;
    assign abort_hit = abort && ((state_q == PUSH) || (state_q == POP));

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

    assign stk_push  = (state_q == PUSH) && live;
    assign stk_in    = stk_push && shreg_q[0];
    assign bit_valid = (state_q == POP) && live;
    assign bit_data  = bit_valid && stk_out;
    assign bit_last  = bit_valid && (cnt_q == last_cnt);
    assign stk_pop   = bit_valid && bit_ready;
    assign stk_clear = reset || (state_q == CLR);

    // Sequencer FSM: capture word, push len bits, pop len bits, or clear on abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && (len_sat != '0)) begin
                        shreg_q <= in_data;
                        len_q   <= len_sat;
                        cnt_q   <= '0;
                        state_q <= PUSH;
                    end
                end
                PUSH: begin
                    if (abort) begin
                        cnt_q   <= '0;
                        state_q <= CLR;
                    end else begin
                        shreg_q <= shreg_q >> 1;
                        if (cnt_q == last_cnt) begin
                            cnt_q   <= '0;
                            state_q <= POP;
                        end else begin
                            cnt_q <= cnt_q + LEN_W'(1);
                        end
                    end
                end
                POP: begin
                    if (abort) begin
                        cnt_q   <= '0;
                        state_q <= CLR;
                    end else if (bit_ready) begin
                        if (cnt_q == last_cnt) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + LEN_W'(1);
                        end
                    end
                end
                CLR: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef SERIAL_STACK_SEQ_STATS_EN
    logic [15:0] words_done_q;
    logic [7:0]  aborts_q;

    // Completed-word counter (wrapping) and honoured-abort counter (saturating).
    always_ff @(posedge clk) begin
        if (reset) begin
            words_done_q <= '0;
            aborts_q     <= '0;
        end else begin
            if (stk_pop && bit_last) begin
                words_done_q <= words_done_q + 16'd1;
            end
            if (abort_hit && (aborts_q != 8'hFF)) begin
                aborts_q <= aborts_q + 8'd1;
            end
        end
    end

    assign words_done = words_done_q;
    assign aborts     = aborts_q;
`else
    logic unused_abort_hit;
    assign unused_abort_hit = abort_hit;
`endif

endmodule

// File: tb/tb_serial_stack_seq.sv
// Directed bench for serial_stack_seq with a behavioural serial_stack model
// attached to the stk_* pins.
module tb_serial_stack_seq;
    import serial_stack_pkg::*;

    localparam int NB = 16;
    localparam int LW = len_w(NB);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [NB-1:0] in_data = '0;
    logic [LW-1:0] in_len = '0;
    logic          abort = 1'b0;
    logic          bit_valid;
    logic          bit_ready = 1'b0;
    logic          bit_data;
    logic          bit_last;
    logic          busy;
    logic [1:0]    state_dbg;
    logic          stk_push;
    logic          stk_pop;
    logic          stk_clear;
    logic          stk_in;
    logic          stk_out;
`ifdef SERIAL_STACK_SEQ_STATS_EN
    logic [15:0]   words_done;
    logic [7:0]    aborts;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int push_total = 0;
    int depth = 0;
    logic [NB-1:0] stk_mem = '0;
    logic [0:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    serial_stack_seq #(.NUM_BITS(NB)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_len    (in_len),
        .abort     (abort),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .bit_data  (bit_data),
        .bit_last  (bit_last),
        .busy      (busy),
        .state_dbg (state_dbg),
        .stk_push  (stk_push),
        .stk_pop   (stk_pop),
        .stk_clear (stk_clear),
        .stk_in    (stk_in),
        .stk_out   (stk_out)
`ifdef SERIAL_STACK_SEQ_STATS_EN
        ,
        .words_done(words_done),
        .aborts    (aborts)
`endif
    );

    // behavioural serial_stack: clear beats push beats pop
    always @(posedge clk) begin
        if (stk_clear) begin
            depth <= 0;
        end else if (stk_push) begin
            if (depth < NB) stk_mem[depth] <= stk_in;
            depth <= depth + 1;
        end else if (stk_pop && depth > 0) begin
            depth <= depth - 1;
        end
        if (stk_push) push_total <= push_total + 1;
    end

    always_comb begin
        stk_out = 1'b0;
        if (depth > 0 && depth <= NB) stk_out = stk_mem[depth-1];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // per-cycle invariants
    initial begin
        forever begin
            @(negedge clk);
            #2;
            check("push_pop_excl", 32'(stk_push & stk_pop), 0);
            check("clear_excl", 32'(stk_clear & (stk_push | stk_pop)), 0);
            check("depth_max", 32'(depth > NB), 0);
        end
    end

    // driver tasks
    task automatic load_exp(input logic [NB-1:0] d, input int n);
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(d[i]);
    endtask

    task automatic send_word(input logic [NB-1:0] d, input logic [LW-1:0] l);
        @(negedge clk);
        in_data  = d;
        in_len   = l;
        in_valid = 1'b1;
        #1;
        check("in_ready_at_send", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Consume nbits stream bits; stall_mode drops bit_ready every other cycle.
    task automatic collect(input int nbits, input int stall_mode, output int lat);
        int   got;
        int   cyc;
        logic held_v;
        logic hd;
        logic hl;
        logic rdy_tog;
        logic e;
        got = 0; cyc = 0; held_v = 1'b0; hd = 1'b0; hl = 1'b0; rdy_tog = 1'b0;
        lat = -1;
        while (got < nbits && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (stall_mode != 0) begin
                bit_ready = rdy_tog;
                rdy_tog = ~rdy_tog;
            end else begin
                bit_ready = 1'b1;
            end
            #1;
            if (bit_valid && lat < 0) lat = cyc;
            if (held_v) begin
                check("stall_data", 32'(bit_data), 32'(hd));
                check("stall_last", 32'(bit_last), 32'(hl));
            end
            held_v = bit_valid && !bit_ready;
            hd = bit_data;
            hl = bit_last;
            check("pop_is_handshake", 32'(stk_pop), 32'(bit_valid & bit_ready));
            if (bit_valid && bit_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_bit", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("bit_data", 32'(bit_data), 32'(e));
                    check("bit_last", 32'(bit_last), 32'(exp_q.size() == 0));
                end
                got++;
            end
        end
        if (got < nbits) check("collect_timeout", got, nbits);
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        bit_ready = 1'b0;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_depth"}, depth, 0);
        check({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
    endtask

    initial begin
        int lat;
        int base;

        // reset
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_stk_clear", 32'(stk_clear), 1);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_bit_valid", 32'(bit_valid), 0);
        check("rst_outputs", 32'({stk_push, stk_pop, stk_clear, stk_in, bit_last, bit_data}), 0);

        // 1: full word, free-running consumer
        base = push_total;
        load_exp(16'hA5C3, 16);
        send_word(16'hA5C3, 16);
        collect(16, 0, lat);
        check("t1_latency", lat, 17);
        check("t1_pushes", push_total - base, 16);
        check_idle("t1");

        // 2: short word
        base = push_total;
        load_exp(16'h000B, 4);
        send_word(16'h000B, 4);
        collect(4, 0, lat);
        check("t2_latency", lat, 5);
        check("t2_pushes", push_total - base, 4);
        check_idle("t2");

        // 3: backpressure
        load_exp(16'hA5C3, 16);
        send_word(16'hA5C3, 16);
        collect(16, 1, lat);
        check_idle("t3");

        // 4: abort on the 3rd popped bit
        load_exp(16'hA5C3, 16);
        send_word(16'hA5C3, 16);
        collect(2, 0, lat);
        @(negedge clk);
        abort = 1'b1;
        #1;
        check("t4_abort_state", 32'(state_dbg), 32'(POP));
        check("t4_abort_no_valid", 32'(bit_valid), 0);
        check("t4_abort_no_pop", 32'(stk_pop), 0);
        check("t4_abort_no_clear_yet", 32'(stk_clear), 0);
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("t4_clr_state", 32'(state_dbg), 32'(CLR));
        check("t4_stk_clear", 32'(stk_clear), 1);
        check("t4_clr_in_ready", 32'(in_ready), 0);
        @(negedge clk);
        #1;
        check("t4_clear_one_cycle", 32'(stk_clear), 0);
        check("t4_in_ready", 32'(in_ready), 1);
        check("t4_depth", depth, 0);
        exp_q.delete();
`ifdef SERIAL_STACK_SEQ_STATS_EN
        check("stats_words_done", 32'(words_done), 3);
        check("stats_aborts", 32'(aborts), 1);
`endif
        load_exp(16'h8001, 16);
        send_word(16'h8001, 16);
        collect(16, 0, lat);
        check("t4b_latency", lat, 17);
        check_idle("t4b");

        // 5: zero-length word, abort in IDLE, oversize length
        base = push_total;
        send_word(16'hFFFF, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            abort = (i == 1);
            #1;
            check("t5_in_ready", 32'(in_ready), 1);
            check("t5_bit_valid", 32'(bit_valid), 0);
            check("t5_no_clear", 32'(stk_clear), 0);
        end
        abort = 1'b0;
        check("t5_no_push", push_total - base, 0);
        base = push_total;
        load_exp(16'h1234, 16);
        send_word(16'h1234, 20);
        collect(16, 0, lat);
        check("t5_sat_latency", lat, 17);
        check("t5_sat_pushes", push_total - base, 16);
        check_idle("t5");

        // 6: reset in the middle of the push phase (cnt=7)
        send_word(16'hA5C3, 16);
        repeat (7) @(negedge clk);
        @(negedge clk);
        #1;
        check("t6_pre_state", 32'(state_dbg), 32'(PUSH));
        check("t6_pre_depth", depth, 7);
        reset = 1'b1;
        #1;
        check("t6_rst_clear", 32'(stk_clear), 1);
        check("t6_rst_no_push", 32'(stk_push), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t6_in_ready", 32'(in_ready), 1);
        check("t6_busy", 32'(busy), 0);
        check("t6_state", 32'(state_dbg), 32'(IDLE));
        check("t6_outputs", 32'({bit_valid, stk_push, stk_pop, stk_clear, stk_in, bit_last, bit_data}), 0);
        check("t6_depth", depth, 0);
        exp_q.delete();

        // final report
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
